// File: rtl/rv32i_header.sv
// rv32i_header: shared widths, one-hot indices, opcode fields and ALU-op helpers for the RV32I pipeline.
package rv32i_header;
    localparam int ALU_WIDTH = 14;
    localparam int OPCODE_WIDTH = 11;
    localparam int EXCEPTION_WIDTH = 4;

    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;
    localparam int ALU_SLT = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_XOR = 4;
    localparam int ALU_OR = 5;
    localparam int ALU_AND = 6;
    localparam int ALU_SLL = 7;
    localparam int ALU_SRL = 8;
    localparam int ALU_SRA = 9;
    localparam int ALU_EQ = 10;
    localparam int ALU_NEQ = 11;
    localparam int ALU_GE = 12;
    localparam int ALU_GEU = 13;

    localparam int OP_RTYPE = 0;
    localparam int OP_ITYPE = 1;
    localparam int OP_LOAD = 2;
    localparam int OP_STORE = 3;
    localparam int OP_BRANCH = 4;
    localparam int OP_JAL = 5;
    localparam int OP_JALR = 6;
    localparam int OP_LUI = 7;
    localparam int OP_AUIPC = 8;
    localparam int OP_SYSTEM = 9;
    localparam int OP_FENCE = 10;

    localparam int EXC_ILLEGAL = 0;
    localparam int EXC_ECALL = 1;
    localparam int EXC_EBREAK = 2;
    localparam int EXC_MRET = 3;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE = 7'b0001111;

    typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_class_t;

    function automatic logic [ALU_WIDTH-1:0] alu_arith(input logic [2:0] f3, input logic alt);
        logic [ALU_WIDTH-1:0] r;
        r = '0;
        case (f3)
            3'b000: r[alt ? ALU_SUB : ALU_ADD] = 1'b1;
            3'b001: r[ALU_SLL] = 1'b1;
            3'b010: r[ALU_SLT] = 1'b1;
            3'b011: r[ALU_SLTU] = 1'b1;
            3'b100: r[ALU_XOR] = 1'b1;
            3'b101: r[alt ? ALU_SRA : ALU_SRL] = 1'b1;
            3'b110: r[ALU_OR] = 1'b1;
            default: r[ALU_AND] = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [ALU_WIDTH-1:0] alu_branch(input logic [2:0] f3);
        logic [ALU_WIDTH-1:0] r;
        r = '0;
        case (f3)
            3'b000: r[ALU_EQ] = 1'b1;
            3'b001: r[ALU_NEQ] = 1'b1;
            3'b100: r[ALU_SLT] = 1'b1;
            3'b101: r[ALU_GE] = 1'b1;
            3'b110: r[ALU_SLTU] = 1'b1;
            3'b111: r[ALU_GEU] = 1'b1;
            default: r = '0;
        endcase
        return r;
    endfunction
endpackage

// File: rtl/rv32i_imm_gen.sv
// rv32i_imm_gen: combinational sign-extended immediate builder selected by instruction format class.
module rv32i_imm_gen
    import rv32i_header::*;
(
    input  logic [31:0] inst,
    input  logic [2:0]  cls,
    output logic [31:0] imm
);
    always_comb begin
        imm = (cls == IMM_I) ? {{20{inst[31]}}, inst[31:20]} :
              (cls == IMM_S) ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
              (cls == IMM_B) ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
              (cls == IMM_U) ? {inst[31:12], 12'b0} :
              (cls == IMM_J) ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
              32'd0;
    end
endmodule

// File: rtl/rv32i_decoder.sv
// rv32i_decoder: RV32I decode stage producing one-hot ALU/opcode/exception bundles with ce/stall/flush handshake.
// Define RV32E_EN to restrict the register file to x0-x15 (higher addresses decode as ILLEGAL).
module rv32i_decoder
    import rv32i_header::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [31:0]                i_inst,
    input  logic [31:0]                i_pc,
    input  logic                       i_ce,
    input  logic                       i_stall,
    input  logic                       i_force_stall,
    input  logic                       i_flush,
    output logic [4:0]                 o_rs1_addr_rf,
    output logic [4:0]                 o_rs2_addr_rf,
    output logic [4:0]                 o_rs1_addr,
    output logic [4:0]                 o_rs2_addr,
    output logic [4:0]                 o_rd_addr,
    output logic [31:0]                o_imm,
    output logic [2:0]                 o_funct3,
    output logic [ALU_WIDTH-1:0]       o_alu,
    output logic [OPCODE_WIDTH-1:0]    o_opcode,
    output logic [EXCEPTION_WIDTH-1:0] o_exception,
    output logic [31:0]                o_pc,
    output logic                       o_ce,
    output logic                       o_stall,
    output logic                       o_flush
);
`ifdef RV32E_EN
    localparam logic RV32E = 1'b1;
`else
    localparam logic RV32E = 1'b0;
`endif
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [11:0] f12;
    imm_class_t cls;
    logic illegal, bad, use_rs1, use_rs2, use_rd, stall_bit;
    logic [ALU_WIDTH-1:0] alu_d;
    logic [OPCODE_WIDTH-1:0] opc_d;
    logic [EXCEPTION_WIDTH-1:0] sys_exc;
    logic [31:0] imm_d;

    assign opc = i_inst[6:0];
    assign f3 = i_inst[14:12];
    assign f7 = i_inst[31:25];
    assign f12 = i_inst[31:20];
    assign o_rs1_addr_rf = i_inst[19:15];
    assign o_rs2_addr_rf = i_inst[24:20];
    assign o_stall = (i_stall | i_force_stall) & ~i_flush;
    assign o_flush = i_flush;
    assign stall_bit = o_stall | i_stall;

    rv32i_imm_gen u_imm_gen (.inst(i_inst), .cls(cls), .imm(imm_d));

    always_comb begin
        alu_d = '0;
        opc_d = '0;
        sys_exc = '0;
        cls = IMM_R;
        illegal = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd = 1'b0;
        case (opc)
            OPC_RTYPE: begin
                opc_d[OP_RTYPE] = 1'b1;
                alu_d = alu_arith(f3, f7[5]);
                illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
                {use_rs1, use_rs2, use_rd} = 3'b111;
            end
            OPC_ITYPE: begin
                opc_d[OP_ITYPE] = 1'b1;
                cls = IMM_I;
                alu_d = alu_arith(f3, f3 == 3'b101 && f7[5]);
                illegal = (f3 == 3'b001 && f7 != 7'h00) ||
                          (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
                {use_rs1, use_rd} = 2'b11;
            end
            OPC_LOAD: begin
                opc_d[OP_LOAD] = 1'b1;
                cls = IMM_I;
                alu_d[ALU_ADD] = 1'b1;
                {use_rs1, use_rd} = 2'b11;
            end
            OPC_STORE: begin
                opc_d[OP_STORE] = 1'b1;
                cls = IMM_S;
                alu_d[ALU_ADD] = 1'b1;
                {use_rs1, use_rs2} = 2'b11;
            end
            OPC_BRANCH: begin
                opc_d[OP_BRANCH] = 1'b1;
                cls = IMM_B;
                alu_d = alu_branch(f3);
                illegal = f3 == 3'b010 || f3 == 3'b011;
                {use_rs1, use_rs2} = 2'b11;
            end
            OPC_JAL: begin
                opc_d[OP_JAL] = 1'b1;
                cls = IMM_J;
                alu_d[ALU_ADD] = 1'b1;
                use_rd = 1'b1;
            end
            OPC_JALR: begin
                opc_d[OP_JALR] = 1'b1;
                cls = IMM_I;
                alu_d[ALU_ADD] = 1'b1;
                illegal = f3 != 3'b000;
                {use_rs1, use_rd} = 2'b11;
            end
            OPC_LUI, OPC_AUIPC: begin
                opc_d[opc == OPC_LUI ? OP_LUI : OP_AUIPC] = 1'b1;
                cls = IMM_U;
                alu_d[ALU_ADD] = 1'b1;
                use_rd = 1'b1;
            end
            OPC_SYSTEM: begin
                opc_d[OP_SYSTEM] = 1'b1;
                cls = IMM_I;
                if (f3 == 3'b000) begin
                    sys_exc[EXC_ECALL] = f12 == 12'h000;
                    sys_exc[EXC_EBREAK] = f12 == 12'h001;
                    sys_exc[EXC_MRET] = f12 == 12'h302;
                    illegal = sys_exc == '0;
                end else begin
                    // funct3 100 is the only reserved slot among CSR encodings
                    illegal = f3 == 3'b100;
                    use_rs1 = ~f3[2];
                    use_rd = 1'b1;
                end
            end
            OPC_FENCE: begin
                opc_d[OP_FENCE] = 1'b1;
                cls = IMM_I;
            end
            default: illegal = 1'b1;
        endcase
        bad = illegal || i_inst[1:0] != 2'b11 ||
              (RV32E && ((use_rs1 && i_inst[19]) || (use_rs2 && i_inst[24]) || (use_rd && i_inst[11])));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rs1_addr <= '0;
            o_rs2_addr <= '0;
            o_rd_addr <= '0;
            o_imm <= '0;
            o_funct3 <= '0;
            o_alu <= '0;
            o_opcode <= '0;
            o_exception <= '0;
            o_pc <= RESET_PC;
            o_ce <= 1'b0;
        end else begin
            if (i_ce && !stall_bit) begin
                o_rs1_addr <= i_inst[19:15];
                o_rs2_addr <= i_inst[24:20];
                o_rd_addr <= i_inst[11:7];
                o_imm <= imm_d;
                o_funct3 <= f3;
                o_alu <= bad ? '0 : alu_d;
                o_opcode <= bad ? '0 : opc_d;
                o_exception <= bad ? EXCEPTION_WIDTH'(1 << EXC_ILLEGAL) : sys_exc;
                o_pc <= i_pc;
            end
            // a force_stall without downstream stall inserts a bubble; a pending flush waits for stall release
            o_ce <= (i_flush && !stall_bit) ? 1'b0 : !stall_bit ? i_ce : !i_stall ? 1'b0 : o_ce;
        end
    end
endmodule

// File: tb/tb_rv32i_decoder.sv
// tb_rv32i_decoder: directed-vector self-checking bench for the RV32I decode stage.
module tb_rv32i_decoder;
    import rv32i_header::*;
    localparam logic [31:0] RPC = 32'h0000_1000;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] i_inst = '0;
    logic [31:0] i_pc = '0;
    logic i_ce = 1'b0;
    logic i_stall = 1'b0;
    logic i_force_stall = 1'b0;
    logic i_flush = 1'b0;
    logic [4:0] rs1_rf, rs2_rf, rs1, rs2, rd;
    logic [31:0] imm, pc;
    logic [2:0] f3;
    logic [ALU_WIDTH-1:0] alu;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [EXCEPTION_WIDTH-1:0] exc;
    logic ce, stall, flush;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32i_decoder #(.RESET_PC(RPC)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_inst(i_inst), .i_pc(i_pc), .i_ce(i_ce),
        .i_stall(i_stall), .i_force_stall(i_force_stall), .i_flush(i_flush),
        .o_rs1_addr_rf(rs1_rf), .o_rs2_addr_rf(rs2_rf), .o_rs1_addr(rs1), .o_rs2_addr(rs2),
        .o_rd_addr(rd), .o_imm(imm), .o_funct3(f3), .o_alu(alu), .o_opcode(opcode),
        .o_exception(exc), .o_pc(pc), .o_ce(ce), .o_stall(stall), .o_flush(flush)
    );

    task automatic drive(input logic [31:0] inst, input logic [31:0] p);
        i_inst = inst;
        i_pc = p;
        i_ce = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({ce, pc} !== {1'b0, RPC}) begin
            errors++;
            $display("FAIL reset_ce_pc: got ce=%0b pc=%h, want ce=0 pc=%h", ce, pc, RPC);
        end
        checks++;
        if ({rs1, rs2, rd, imm, f3, alu, opcode, exc} !== '0) begin
            errors++;
            $display("FAIL reset_payload: got rd=%0d imm=%h alu=%h opc=%h exc=%h, want all 0", rd, imm, alu, opcode, exc);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu_ops;
        i_inst = 32'hFFD08293;
        #1;
        checks++;
        if ({rs1_rf, rs2_rf} !== {5'd1, 5'd29}) begin
            errors++;
            $display("FAIL rf_addr: got rs1=%0d rs2=%0d, want 1 29", rs1_rf, rs2_rf);
        end
        @(negedge clk);
        drive(32'hFFD08293, 32'h100);
        checks++;
        if ({ce, alu, opcode, imm, rd, rs1, pc} !== {1'b1, 14'h0001, 11'h002, 32'hFFFFFFFD, 5'd5, 5'd1, 32'h100}) begin
            errors++;
            $display("FAIL addi: got ce=%0b alu=%h opc=%h imm=%h rd=%0d rs1=%0d pc=%h", ce, alu, opcode, imm, rd, rs1, pc);
        end
        drive(32'h402081B3, 32'h104);
        checks++;
        if ({alu, opcode, rs2, rd, imm, exc} !== {14'h0002, 11'h001, 5'd2, 5'd3, 32'd0, 4'd0}) begin
            errors++;
            $display("FAIL sub: got alu=%h opc=%h rs2=%0d rd=%0d imm=%h exc=%h", alu, opcode, rs2, rd, imm, exc);
        end
        drive(32'hFE20CCE3, 32'h108);
        checks++;
        if ({alu, opcode, imm, f3} !== {14'h0004, 11'h010, 32'hFFFFFFF8, 3'b100}) begin
            errors++;
            $display("FAIL blt: got alu=%h opc=%h imm=%h f3=%b", alu, opcode, imm, f3);
        end
        drive(32'h4030D093, 32'h10C);
        checks++;
        if ({alu, opcode, imm} !== {14'h0200, 11'h002, 32'h00000403}) begin
            errors++;
            $display("FAIL srai: got alu=%h opc=%h imm=%h", alu, opcode, imm);
        end
    endtask

    task automatic test_imm_classes;
        drive(32'h0020A423, 32'h200);
        checks++;
        if ({alu, opcode, imm, rs1, rs2} !== {14'h0001, 11'h008, 32'd8, 5'd1, 5'd2}) begin
            errors++;
            $display("FAIL sw: got alu=%h opc=%h imm=%h rs1=%0d rs2=%0d", alu, opcode, imm, rs1, rs2);
        end
        drive(32'h123453B7, 32'h204);
        checks++;
        if ({opcode, imm, rd} !== {11'h080, 32'h12345000, 5'd7}) begin
            errors++;
            $display("FAIL lui: got opc=%h imm=%h rd=%0d", opcode, imm, rd);
        end
        drive(32'hFFDFF0EF, 32'h208);
        checks++;
        if ({alu, opcode, imm, rd} !== {14'h0001, 11'h020, 32'hFFFFFFFC, 5'd1}) begin
            errors++;
            $display("FAIL jal: got alu=%h opc=%h imm=%h rd=%0d", alu, opcode, imm, rd);
        end
        drive(32'h01000893, 32'h20C);
`ifdef RV32E_EN
        checks++;
        if ({exc, alu, opcode} !== {4'b0001, 14'h0, 11'h0}) begin
            errors++;
            $display("FAIL rv32e_x17: got exc=%b alu=%h opc=%h, want illegal", exc, alu, opcode);
        end
`else
        checks++;
        if ({exc, opcode, rd, imm} !== {4'b0000, 11'h002, 5'd17, 32'd16}) begin
            errors++;
            $display("FAIL addi_x17: got exc=%b opc=%h rd=%0d imm=%h", exc, opcode, rd, imm);
        end
`endif
    endtask

    task automatic test_system;
        drive(32'h00000073, 32'h300);
        checks++;
        if ({exc, opcode, alu} !== {4'b0010, 11'h200, 14'h0}) begin
            errors++;
            $display("FAIL ecall: got exc=%b opc=%h alu=%h", exc, opcode, alu);
        end
        drive(32'h00100073, 32'h304);
        checks++;
        if (exc !== 4'b0100) begin
            errors++;
            $display("FAIL ebreak: got exc=%b want 0100", exc);
        end
        drive(32'h30200073, 32'h308);
        checks++;
        if (exc !== 4'b1000) begin
            errors++;
            $display("FAIL mret: got exc=%b want 1000", exc);
        end
        drive(32'h30002073, 32'h30C);
        checks++;
        if ({exc, opcode} !== {4'b0000, 11'h200}) begin
            errors++;
            $display("FAIL csrrs: got exc=%b opc=%h", exc, opcode);
        end
    endtask

    task automatic test_illegal;
        drive(32'hFFFFFFFF, 32'h400);
        checks++;
        if ({exc, alu, opcode, ce} !== {4'b0001, 14'h0, 11'h0, 1'b1}) begin
            errors++;
            $display("FAIL illegal_ff: got exc=%b alu=%h opc=%h ce=%0b", exc, alu, opcode, ce);
        end
        drive(32'h02309093, 32'h404);
        checks++;
        if ({exc, alu} !== {4'b0001, 14'h0}) begin
            errors++;
            $display("FAIL illegal_slli: got exc=%b alu=%h", exc, alu);
        end
        drive(32'h0020A063, 32'h408);
        checks++;
        if ({exc, opcode} !== {4'b0001, 11'h0}) begin
            errors++;
            $display("FAIL illegal_branch: got exc=%b opc=%h", exc, opcode);
        end
        drive(32'h00000013 & 32'hFFFFFFFC, 32'h40C);
        checks++;
        if (exc !== 4'b0001) begin
            errors++;
            $display("FAIL illegal_compressed: got exc=%b want 0001", exc);
        end
    endtask

    task automatic test_stall;
        drive(32'hFFD08293, 32'h500);
        i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_inst = 32'h402081B3 + 32'(i << 7);
            i_pc = 32'h504 + 32'(i * 4);
            #1;
            checks++;
            if (stall !== 1'b1) begin
                errors++;
                $display("FAIL stall_out[%0d]: got %0b want 1", i, stall);
            end
            @(negedge clk);
            checks++;
            if ({ce, rd, pc, alu} !== {1'b1, 5'd5, 32'h500, 14'h0001}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got ce=%0b rd=%0d pc=%h alu=%h", i, ce, rd, pc, alu);
            end
        end
        i_stall = 1'b0;
        i_force_stall = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL force_stall_out: got %0b want 1", stall);
        end
        @(negedge clk);
        checks++;
        if ({ce, rd} !== {1'b0, 5'd5}) begin
            errors++;
            $display("FAIL force_bubble: got ce=%0b rd=%0d, want ce=0 rd=5", ce, rd);
        end
        i_force_stall = 1'b0;
        drive(32'h402081B3, 32'h520);
        checks++;
        if ({ce, rd} !== {1'b1, 5'd3}) begin
            errors++;
            $display("FAIL after_force: got ce=%0b rd=%0d", ce, rd);
        end
    endtask

    task automatic test_flush;
        i_flush = 1'b1;
        i_inst = 32'hFFD08293;
        #1;
        checks++;
        if ({flush, stall} !== 2'b10) begin
            errors++;
            $display("FAIL flush_comb: got flush=%0b stall=%0b, want 1 0", flush, stall);
        end
        @(negedge clk);
        checks++;
        if (ce !== 1'b0) begin
            errors++;
            $display("FAIL flush_ce: got %0b want 0", ce);
        end
        i_flush = 1'b0;
        drive(32'hFFD08293, 32'h600);
        i_stall = 1'b1;
        i_flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_masks_stall: got %0b want 0", stall);
        end
        @(negedge clk);
        checks++;
        if (ce !== 1'b1) begin
            errors++;
            $display("FAIL flush_during_stall: got ce=%0b want 1", ce);
        end
        i_stall = 1'b0;
        @(negedge clk);
        checks++;
        if (ce !== 1'b0) begin
            errors++;
            $display("FAIL flush_after_release: got ce=%0b want 0", ce);
        end
        i_flush = 1'b0;
    endtask

    task automatic test_reset_in_stall;
        drive(32'hFFD08293, 32'h700);
        i_stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ce, pc, rd, imm} !== {1'b0, RPC, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_mid_stall: got ce=%0b pc=%h rd=%0d imm=%h", ce, pc, rd, imm);
        end
        @(negedge clk);
        rst_n = 1'b1;
        i_stall = 1'b0;
        i_ce = 1'b0;
        @(negedge clk);
        checks++;
        if ({ce, pc} !== {1'b0, RPC}) begin
            errors++;
            $display("FAIL reset_no_retain: got ce=%0b pc=%h", ce, pc);
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_imm_classes();
        test_system();
        test_illegal();
        test_stall();
        test_flush();
        test_reset_in_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv32i_decoder.md
Name: rv32i_decoder

Overview:
Decode stage of the RV32I core. It sits between fetch and rv32i_alu, and it produces the one-hot ALU-op, one-hot opcode and exception bundles that the ALU stage consumes. It takes a 32-bit instruction and its PC, extracts register addresses, builds a sign-extended immediate, flags illegal and system instructions, and registers everything into the pipeline. It uses the same ce/stall/flush handshake as the ALU stage.

Parameters:
- RESET_PC, 32'h0000_0000, reset value of o_pc.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_inst  in  32  instruction from fetch
- i_pc  in  32  PC of i_inst
- i_ce  in  1  fetch output valid
- i_stall  in  1  stall from downstream stages
- i_force_stall  in  1  external stall request
- i_flush  in  1  flush request
- o_rs1_addr_rf / o_rs2_addr_rf  out  5 each  combinational regfile read addresses (i_inst[19:15], i_inst[24:20])
- o_rs1_addr / o_rs2_addr / o_rd_addr  out  5 each  registered addresses
- o_imm  out  32  registered sign-extended immediate
- o_funct3  out  3  registered
- o_alu  out  ALU_WIDTH  registered one-hot ALU op
- o_opcode  out  OPCODE_WIDTH  registered one-hot opcode class
- o_exception  out  EXCEPTION_WIDTH  registered one-hot exception
- o_pc  out  32  registered PC
- o_ce  out  1  decode output valid
- o_stall  out  1  stall to fetch
- o_flush  out  1  flush to fetch

Behaviour:
- Reset (async, i_rst_n=0):
  - o_ce=0, o_pc=RESET_PC.
  - All other registered outputs 0.
  - Reset mid-stall drops the held instruction. No output is retained.
- Stall:
  - stall_bit = o_stall | i_stall.
  - o_stall = (i_stall | i_force_stall) & ~i_flush. Combinational.
  - o_flush = i_flush. Combinational.
- Register update:
  - Payload registers load when i_ce & ~stall_bit. Latency is one cycle.
  - Under stall_bit, payload holds.
- o_ce next-state:
  - i_flush & ~stall_bit: 0.
  - else ~stall_bit: i_ce.
  - else stall_bit & ~i_stall: 0. This is the bubble when only force_stall is asserted.
  - else hold.
  - When flush and stall arrive in the same cycle, flush wins only once the stall releases.
- Immediate by class (sign bit is i_inst[31]):
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R-type: 0.
- Opcode one-hot order: RTYPE, ITYPE, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, FENCE.
- ALU one-hot order: ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA, EQ, NEQ, GE, GEU.
- ALU mapping:
  - R and I types by funct3; funct7[5] selects SUB and SRA.
  - Branch: BEQ→EQ, BNE→NEQ, BLT→SLT, BGE→GE, BLTU→SLTU, BGEU→GEU.
  - LOAD, STORE, JAL, JALR, LUI, AUIPC → ADD.
  - SYSTEM and FENCE → o_alu = 0.
- Exception one-hot order: ILLEGAL, ECALL, EBREAK, MRET.
- ILLEGAL is raised for:
  - inst[1:0] != 2'b11.
  - Unknown opcode.
  - R-type with funct7 not 0x00 or 0x20, or 0x20 with funct3 not 000 or 101.
  - SLLI with inst[31:25] != 0.
  - SRLI/SRAI with inst[31:25] not 0x00 or 0x20.
  - Branch funct3 of 010 or 011.
  - JALR funct3 != 0.
- SYSTEM with funct3=0:
  - inst[31:20]=0x000 → ECALL.
  - 0x001 → EBREAK.
  - 0x302 → MRET.
  - anything else → ILLEGAL.
  - CSR funct3 values set SYSTEM with no exception.
- On ILLEGAL, o_opcode=0 and o_alu=0, but o_ce still follows i_ce. The trap is handled downstream.
- Exactly one exception bit is set at most.

Optional Feature:
- RV32E_EN: when defined, any used rs1/rs2/rd address with bit 4 set raises ILLEGAL. The register file is x0–x15 only.
- When not defined, all 32 registers are legal.

Decomposition:
- rv32i_header package holds ALU_WIDTH=14, OPCODE_WIDTH=11, EXCEPTION_WIDTH=4, and the one-hot index constants.
- The package also holds the 7-bit opcode field constants (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011, 0001111).
- Sub-module rv32i_imm_gen: combinational immediate builder, taking instruction and class and returning 32 bits.

Test Plan:
- 0xFFD08293 (ADDI x5,x1,-3), i_ce=1 → next cycle: o_ce=1, o_alu[ADD]=1, o_opcode[ITYPE]=1, o_imm=0xFFFFFFFD, o_rd_addr=5, o_rs1_addr=1.
- 0x402081B3 (SUB x3,x1,x2) → o_alu[SUB]=1, o_opcode[RTYPE]=1, o_rs2_addr=2, o_imm=0.
- 0xFE20CCE3 (BLT x1,x2,-8) → o_alu[SLT]=1, o_opcode[BRANCH]=1, o_imm=0xFFFFFFF8, o_funct3=3'b100.
- 0x00000073 → o_exception[ECALL]=1. 0x30200073 → o_exception[MRET]=1. 0xFFFFFFFF → o_exception[ILLEGAL]=1, o_alu=0, o_ce=1.
- Stall/flush sequence:
  - i_stall=1 for 3 cycles while i_inst changes → outputs hold, o_stall=1.
  - i_force_stall=1 alone → o_ce=0 next cycle.
  - i_flush=1, no stall → o_ce=0 next cycle, o_flush=1 same cycle.
- Drop i_rst_n during a stall → o_ce=0 and o_pc=RESET_PC immediately. With RV32E_EN, 0x01000893 (ADDI x17,x0,16) → ILLEGAL.
